// File: rtl/rr_arb_mux.sv
// N-channel arbitrated multiplexer: round-robin or fixed-priority grant feeding
// a single stallable output register, with valid/ready handshakes on every port.
module rr_arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned MODE  = 0,
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    localparam int unsigned IDXW = 32;

    logic                free;
    logic                any;
    logic                load;
    logic                found;
    logic [IDXW-1:0]     idx;
    logic [SELW-1:0]     grant;
    logic [SELW-1:0]     ptr;
    logic [SELW-1:0]     ptr_next;
    logic [WIDTH-1:0]    grant_data;
    logic [WIDTH-1:0]    chan_data [N];

    // Unpack the flattened channel bus so the winner can be picked by index.
    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign free = !out_valid || out_ready;
    assign any  = |in_valid;
    assign load = any && free;

    // Winner scan: ascending from ptr with wrap (round-robin) or from 0 (fixed).
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (MODE == 0) begin
                idx = IDXW'((IDXW'(ptr) + IDXW'(k)) % IDXW'(N));
            end else begin
                idx = IDXW'(k);
            end
            if (!found && in_valid[SELW'(idx)]) begin
                found = 1'b1;
                grant = SELW'(idx);
            end
        end
    end

    always_comb begin
        grant_data = chan_data[grant];
    end

    // Only the winner sees ready, and only when the output slot can take a beat.
    always_comb begin
        in_ready = '0;
        if (rst_n && load) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Pointer moves to the slot just past the granted channel.
    always_comb begin
        ptr_next = ptr;
        if (MODE == 0) begin
            if (grant == SELW'(N - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant + SELW'(1);
            end
        end else begin
            ptr_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= ptr_next;
        end
    end

    // Output stage: load replaces the beat (also on a same-cycle pop), drain
    // clears only valid so data/sel keep the last granted values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_sel   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready));

    a_ready_requested: assert property (@(posedge clk) disable iff (!rst_n)
        (in_ready & ~in_valid) == '0);

    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: round-robin N=4, fixed-priority N=4 and N=1 instances
// share one stimulus stream and are compared against a queue-free reference model.
module tb_rr_arb_mux;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     in_valid = '0;
    logic [4*W-1:0] in_data = '0;
    logic           out_ready = 1'b0;

    logic [3:0]     rr_ready, fp_ready;
    logic           rr_valid, fp_valid, one_valid;
    logic [W-1:0]   rr_data, fp_data, one_data;
    logic [1:0]     rr_sel, fp_sel;
    logic [0:0]     one_sel, one_ready;

    int ntests = 0;
    int nfail  = 0;

    // Reference model state per instance: 0 = round-robin, 1 = fixed, 2 = N=1
    int           m_n    [3] = '{4, 4, 1};
    int           m_mode [3] = '{0, 1, 0};
    bit           m_vld  [3];
    logic [W-1:0] m_data [3];
    int           m_sel  [3];
    int           m_ptr  [3];

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(W), .N(4), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_ready), .out_valid(rr_valid), .out_data(rr_data),
        .out_sel(rr_sel), .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(W), .N(4), .MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(fp_ready), .out_valid(fp_valid), .out_data(fp_data),
        .out_sel(fp_sel), .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(W), .N(1), .MODE(0)) u_one (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0:0]), .in_data(in_data[W-1:0]),
        .in_ready(one_ready), .out_valid(one_valid), .out_data(one_data),
        .out_sel(one_sel), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] req_of(input int u);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < m_n[u]; i++) v[i] = in_valid[i];
        return v;
    endfunction

    // Spec rule: first requester found scanning upward from the pointer, wrapping.
    function automatic int winner(input int u);
        logic [3:0] v;
        int j;
        v = req_of(u);
        for (int k = 0; k < m_n[u]; k++) begin
            j = (m_ptr[u] + k) % m_n[u];
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int u);
        int w;
        bit fr;
        w  = winner(u);
        fr = !m_vld[u] || out_ready;
        if (rst_n && fr && w >= 0) return 4'(1 << w);
        return 4'b0000;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            m_vld[u] = 1'b0; m_data[u] = '0; m_sel[u] = 0; m_ptr[u] = 0;
        end
    endtask

    task automatic model_edge();
        int w;
        for (int u = 0; u < 3; u++) begin
            w = winner(u);
            if ((!m_vld[u] || out_ready) && w >= 0) begin
                m_vld[u]  = 1'b1;
                m_data[u] = in_data[w*W +: W];
                m_sel[u]  = w;
                if (m_mode[u] == 0) m_ptr[u] = (w + 1) % m_n[u];
            end else if (out_ready) begin
                m_vld[u] = 1'b0;
            end
        end
    endtask

    task automatic check_ready(input string ph);
        chk({ph, "_rr_in_ready"},  64'(rr_ready),  64'(exp_ready(0)));
        chk({ph, "_fp_in_ready"},  64'(fp_ready),  64'(exp_ready(1)));
        chk({ph, "_one_in_ready"}, 64'(one_ready), 64'(exp_ready(2)));
    endtask

    task automatic check_outs(input string ph);
        chk({ph, "_rr_valid"},  64'(rr_valid),  64'(m_vld[0]));
        chk({ph, "_rr_data"},   64'(rr_data),   64'(m_data[0]));
        chk({ph, "_rr_sel"},    64'(rr_sel),    64'(m_sel[0]));
        chk({ph, "_fp_valid"},  64'(fp_valid),  64'(m_vld[1]));
        chk({ph, "_fp_data"},   64'(fp_data),   64'(m_data[1]));
        chk({ph, "_fp_sel"},    64'(fp_sel),    64'(m_sel[1]));
        chk({ph, "_one_valid"}, 64'(one_valid), 64'(m_vld[2]));
        chk({ph, "_one_data"},  64'(one_data),  64'(m_data[2]));
        chk({ph, "_one_sel"},   64'(one_sel),   64'(m_sel[2]));
    endtask

    // One clock: drive, check combinational ready, clock, check registered outputs.
    task automatic cycle(input string ph, input logic [3:0] v, input logic rdy);
        in_valid  = v;
        out_ready = rdy;
        #1;
        check_ready(ph);
        @(posedge clk);
        model_edge();
        #1;
        check_outs(ph);
    endtask

    task automatic set_seq_data();
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = W'(32'hA0 + i);
    endtask

    task automatic hold_reset(input string ph);
        model_reset();
        #1;
        check_outs(ph);
        check_ready(ph);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_outs(ph);
            check_ready(ph);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};

        model_reset();
        set_seq_data();
        @(posedge clk);
        #1;

        // Reset then idle
        rst_n = 1'b0;
        hold_reset("rst");
        cycle("idle", 4'b0000, 1'b1);
        cycle("idle", 4'b0000, 1'b0);

        // Round-robin fairness with all channels requesting
        for (int i = 0; i < 6; i++) begin
            cycle("rr_fair", 4'b1111, 1'b1);
            chk("rr_fair_seq_sel",  64'(rr_sel),  64'(exp_seq[i]));
            chk("rr_fair_seq_data", 64'(rr_data), 64'(32'hA0 + exp_seq[i]));
        end
        cycle("rr_fair", 4'b1111, 1'b1);
        chk("bp_pre_sel", 64'(rr_sel), 64'd2);

        // Backpressure holds the beat and suppresses ready
        for (int i = 0; i < 3; i++) begin
            cycle("bp", 4'b1111, 1'b0);
            chk("bp_hold_sel",   64'(rr_sel),   64'd2);
            chk("bp_hold_data",  64'(rr_data),  64'h0A2);
            chk("bp_hold_ready", 64'(rr_ready), 64'd0);
        end
        cycle("bp_release", 4'b1111, 1'b1);
        chk("bp_next_sel", 64'(rr_sel), 64'd3);

        // Sparse round-robin wrap starting from pointer 3
        cycle("sparse_setup", 4'b0100, 1'b1);
        chk("sparse_setup_sel", 64'(rr_sel), 64'd2);
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'b0101;
            out_ready = 1'b1;
            #1;
            chk("sparse_no_ready_1_3", 64'(rr_ready & 4'b1010), 64'd0);
            cycle("sparse", 4'b0101, 1'b1);
            chk("sparse_sel", 64'(rr_sel), (i == 1) ? 64'd2 : 64'd0);
        end

        // Fixed priority starves higher indices while channel 1 requests
        for (int i = 0; i < 3; i++) begin
            cycle("fp", 4'b1110, 1'b1);
            chk("fp_sel_1",      64'(fp_sel),             64'd1);
            chk("fp_no_ready_23", 64'(fp_ready & 4'b1100), 64'd0);
        end
        cycle("fp_drop", 4'b1100, 1'b1);
        chk("fp_sel_2", 64'(fp_sel), 64'd2);
        cycle("drain", 4'b0000, 1'b1);

        // Reset asserted mid-cycle during a stall with ptr at 2
        rst_n = 1'b0;
        hold_reset("rst2");
        cycle("mid_setup", 4'b0010, 1'b1);
        cycle("mid_stall", 4'b1111, 1'b0);
        chk("mid_stall_valid", 64'(rr_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_async_valid", 64'(rr_valid), 64'd0);
        check_ready("mid_async");
        @(posedge clk);
        #1;
        hold_reset("mid_rst");
        cycle("mid_after", 4'b1111, 1'b1);
        chk("mid_first_sel", 64'(rr_sel), 64'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 4; c++) in_data[c*W +: W] = W'($urandom);
            cycle("rand", 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
Parametrised N-channel arbitrated multiplexer with a registered output stage and valid/ready handshakes on every channel. It generalises the plain select-driven muxes: the block picks the winning source itself, using either round-robin or fixed priority. It forwards the winner's data through one pipeline register that the downstream consumer can stall. It sits between multiple pipeline requesters (e.g. I-fetch / D-mem / writeback ports) and a shared resource such as the memory bus or a shared register-file write port.

Parameters:
WIDTH, 32, data width per channel in bits
N, 4, number of input channels (1..16)
MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
SELW, derived, $clog2(N), forced to a minimum of 1; width of the grant index

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  N  per-channel request; bit i belongs to channel i
in_data  input  N*WIDTH  flattened channel data; channel i occupies [i*WIDTH +: WIDTH]
in_ready  output  N  per-channel accept; combinational
out_valid  output  1  output register holds a valid beat
out_data  output  WIDTH  data of the granted beat; registered
out_sel  output  SELW  index of the channel that produced out_data; registered
out_ready  input  1  downstream accepts the current beat

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, RR pointer ptr=0. in_ready=0 while rst_n=0.
- Definitions:
  - free = !out_valid || out_ready.
  - any = |in_valid.
  - g = winning index, combinational.
  - load = any && free.
- Round-robin (MODE=0):
  - Scan starts at ptr and ascends, wrapping from N-1 to 0; g is the first index with in_valid set.
  - On load, ptr <= (g==N-1) ? 0 : g+1.
  - ptr is unchanged whenever load=0.
- Fixed priority (MODE=1):
  - g = lowest set index of in_valid.
  - ptr is not used and stays at 0.
- in_ready[i] = free && any && (g==i). At most one bit of in_ready is set; it is 0 for channels not requesting.
- A transfer on channel i happens when in_valid[i] && in_ready[i].
- On load at edge k:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1, visible in cycle k+1
- Latency and throughput: one-cycle latency. Full throughput of 1 beat per cycle while out_ready=1.
- Drain: if !load && out_ready, out_valid <= 0. out_data and out_sel keep their last values (no clearing).
- Stall: while out_valid && !out_ready, out_data, out_sel, out_valid and ptr are held and all in_ready are 0. Sources must hold valid and data; the spec does not check this, it is the source's responsibility.
- Simultaneous pop and push (out_valid && out_ready && any): the new beat replaces the old one in the same edge, with no bubble.
- N=1: always grants channel 0; out_sel is constantly 0.
- Requests that drop before being granted are legal and have no side effect.
- ptr changes only on a granted transfer. A winner that withdraws before load does not advance the pointer.
- Reset mid-operation: an in-flight out_valid beat is discarded, and ptr returns to 0. The first grant after reset release comes from the lowest requesting index.
- Pure synchronous datapath apart from reset. No latches; every combinational path has a default.

Test Plan:
1. Reset then idle: rst_n=0 for 3 cycles, then 1 with in_valid=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000 throughout.
2. Round-robin fairness (MODE=0, N=4): in_valid=1111 held, in_data[i]=32'hA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 with out_data A0,A1,A2,A3,A0,A1, one beat per cycle, first out_valid one cycle after the first load.
3. Backpressure: a beat with out_sel=2 and out_data=A2 is valid; drop out_ready for 3 cycles with in_valid=1111 -> out_data/out_sel stay at A2/2, in_ready=0000, ptr unchanged. When out_ready returns, next out_sel=3.
4. Sparse round-robin wrap: ptr=3, in_valid=0101 -> grant 0, then 2, then 0. in_ready is never set on bits 1 or 3.
5. Fixed priority (MODE=1): in_valid=1110 held, out_ready=1 -> out_sel=1 every cycle. Channels 2 and 3 never see in_ready=1 until in_valid[1] drops, after which out_sel=2.
6. Reset mid-stall: out_valid=1, out_ready=0, ptr=2, then assert rst_n=0 asynchronously mid-cycle -> out_valid=0 immediately. After release with in_valid=1111, the first out_sel=0.
